// File: rtl/pipe_adder.sv
// Segmented-carry pipelined adder/subtractor with valid/ready handshake.
// Each rank adds one SEG-bit slice and hands its carry and the untouched operand slices onward.
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // Subtraction is a + ~b + ~cin, so B and the carry are inverted once on entry.
  assign w_b_eff = b ^ {WIDTH{sub}};
  assign w_c_eff = cin ^ sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * SEG;
    localparam int REM  = WIDTH - LO;
    localparam int DONE = LO + SEG;

    logic [REM-1:0]  w_a_src;
    logic [REM-1:0]  w_b_src;
    logic            w_c_src;
    logic            w_vld_src;
    logic [SEG:0]    w_seg;
    logic [DONE-1:0] w_sum_nxt;

    logic            r_vld;
    logic            r_c;
    logic [DONE-1:0] r_sum;

    if (k == 0) begin : g_src
      assign w_a_src   = a;
      assign w_b_src   = w_b_eff;
      assign w_c_src   = w_c_eff;
      assign w_vld_src = in_valid;
      assign w_sum_nxt = w_seg[SEG-1:0];
    end else begin : g_src
      assign w_a_src   = g_stage[k-1].g_ops.r_a;
      assign w_b_src   = g_stage[k-1].g_ops.r_b;
      assign w_c_src   = g_stage[k-1].r_c;
      assign w_vld_src = g_stage[k-1].r_vld;
      assign w_sum_nxt = {w_seg[SEG-1:0], g_stage[k-1].r_sum};
    end

    assign w_seg = {1'b0, w_a_src[SEG-1:0]} + {1'b0, w_b_src[SEG-1:0]} + {{SEG{1'b0}}, w_c_src};

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_en) begin
        r_vld <= w_vld_src;
        r_c   <= w_seg[SEG];
        r_sum <= w_sum_nxt;
      end
    end

    // Only the operand slices not yet summed travel to the next rank.
    if (k < STAGES - 1) begin : g_ops
      logic [REM-SEG-1:0] r_a;
      logic [REM-SEG-1:0] r_b;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_a_src[REM-1:SEG];
          r_b <= w_b_src[REM-1:SEG];
        end
      end
    end else begin : g_last
      logic r_ovf;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_en) begin
          r_ovf <= (w_a_src[REM-1] == w_b_src[REM-1]) && (w_seg[SEG-1] != w_a_src[REM-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_vld;
  assign y         = g_stage[STAGES-1].r_sum;
  assign cout      = g_stage[STAGES-1].r_c;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule
